gerador_uns: RTL and testbench

- Inverse of the team's ones-counter: takes a count N and serially builds a WIDTH-bit word with exactly N ones, packed from the LSB (word = 2^N - 1).
- Uses the same start/pronto handshake as the ones-counter, so a controller can drive either block identically.
- Split into a control part (FSM) and a datapath part (word shift register plus down-counter).

---
 rtl/gerador_uns_pkg.sv | 18 +
 rtl/gerador_uns_pc.sv | 61 ++++++
 rtl/gerador_uns_po.sv | 51 +++++
 rtl/gerador_uns.sv | 51 +++++
 tb/tb_gerador_uns.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/gerador_uns_pkg.sv
// Shared definitions for the ones-word generator: state codes, default sizes
// and the count clamp helper.
package gerador_uns_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNTW  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    function automatic int unsigned clamp_min(input int unsigned value, input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/gerador_uns_pc.sv
// Control part of the generator: start/pronto handshake FSM driving the datapath.
module gerador_uns_pc
    import gerador_uns_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic zero_b,
    output logic load_b,
    output logic shift_w,
    output logic clr_w,
    output logic pronto,
    output logic busy
);

    state_t state;

    // Datapath strobes act on the same edge as the state transition they belong to.
    always_comb begin
        load_b  = (state == S_IDLE) && start;
        shift_w = (state == S_SHIFT) && !zero_b;
        clr_w   = load_b || !(state inside {S_IDLE, S_SHIFT, S_DONE});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            pronto <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SHIFT;
                        busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (zero_b) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        pronto <= 1'b1;
                    end
                end
                S_DONE: begin
                    // The requester must drop start before another job can begin.
                    if (!start) begin
                        state  <= S_IDLE;
                        pronto <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    pronto <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gerador_uns_po.sv
// Datapath of the generator: word shift register, down-counter B and the
// clamp/saturation flag.
module gerador_uns_po
    import gerador_uns_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNTW-1:0]  count,
    input  logic             load_b,
    input  logic             shift_w,
    input  logic             clr_w,
    output logic [WIDTH-1:0] word,
    output logic             sat,
    output logic             zero_b
);

    logic [CNTW-1:0] b;
    logic [CNTW-1:0] count_clamped;
    logic            count_over;

    always_comb begin
        count_clamped = CNTW'(clamp_min(32'(count), WIDTH));
        count_over    = 32'(count) > WIDTH;
        zero_b        = (b == '0);
    end

    // shift_w is only raised while B is nonzero, so B never wraps below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
            b    <= '0;
            sat  <= 1'b0;
        end else begin
            if (load_b) begin
                b   <= count_clamped;
                sat <= count_over;
            end else if (shift_w) begin
                b <= b - CNTW'(1);
            end
            if (clr_w) begin
                word <= '0;
            end else if (shift_w) begin
                word <= {word[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/gerador_uns.sv
// Ones-word generator: builds a WIDTH-bit word holding min(count, WIDTH)
// ones packed from the LSB, using the start/pronto handshake.
module gerador_uns
    import gerador_uns_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNTW-1:0]  count,
    output logic [WIDTH-1:0] word,
    output logic             pronto,
    output logic             busy,
    output logic             sat
);

    logic load_b;
    logic shift_w;
    logic clr_w;
    logic zero_b;

    gerador_uns_pc u_pc (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .zero_b  (zero_b),
        .load_b  (load_b),
        .shift_w (shift_w),
        .clr_w   (clr_w),
        .pronto  (pronto),
        .busy    (busy)
    );

    gerador_uns_po #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_po (
        .clk     (clk),
        .reset   (reset),
        .count   (count),
        .load_b  (load_b),
        .shift_w (shift_w),
        .clr_w   (clr_w),
        .word    (word),
        .sat     (sat),
        .zero_b  (zero_b)
    );

endmodule

// File: tb/tb_gerador_uns.sv
// Self-checking bench for gerador_uns: directed jobs with literal expectations
// plus a per-cycle comparison against a timing-based behavioural model.
module tb_gerador_uns;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] count;
    logic [7:0] word;
    logic       pronto;
    logic       busy;
    logic       sat;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    gerador_uns dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .count  (count),
        .word   (word),
        .pronto (pronto),
        .busy   (busy),
        .sat    (sat)
    );

    always #5 clk = ~clk;

    // Model: a job accepted at edge k with N = min(count, 8) shows (2^j)-1
    // after edge k+j, and reports completion after edge k+N+1.
    int         cyc = 0;
    int         m_phase = 0;
    int         m_k = 0;
    int         m_n = 0;
    logic [7:0] m_word = 8'h00;
    logic       m_busy = 1'b0;
    logic       m_pronto = 1'b0;
    logic       m_sat = 1'b0;

    always @(posedge clk) begin
        int j;
        cyc++;
        if (reset) begin
            m_phase = 0; m_word = 8'h00; m_busy = 1'b0; m_pronto = 1'b0; m_sat = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_n = (int'(count) > 8) ? 8 : int'(count);
                m_sat = int'(count) > 8;
                m_k = cyc;
                m_word = 8'h00;
                m_busy = 1'b1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            j = cyc - m_k;
            if (j <= m_n) begin
                m_word = 8'((1 << j) - 1);
            end else begin
                m_busy = 1'b0;
                m_pronto = 1'b1;
                m_phase = 2;
            end
        end else if (!start) begin
            m_pronto = 1'b0;
            m_phase = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            checkOutput("cmp_word", 32'(word), 32'(m_word));
            checkOutput("cmp_busy", 32'(busy), 32'(m_busy));
            checkOutput("cmp_pronto", 32'(pronto), 32'(m_pronto));
            checkOutput("cmp_sat", 32'(sat), 32'(m_sat));
        end
    end

    // Called on a falling edge; returns on the falling edge where pronto is first seen.
    task automatic applyStimulus(input logic [3:0] cnt, input logic [7:0] exp_word,
                                 input logic exp_sat, input int exp_lat, input bit disturb);
        int lat = 0;
        int busy_cycles = 0;
        bit seen = 1'b0;
        count = cnt;
        start = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cycles++;
            if (pronto) begin
                seen = 1'b1;
            end else if (disturb) begin
                case (lat)
                    1: start = 1'b0;
                    2: count = 4'd2;
                    3: start = 1'b1;
                    default: ;
                endcase
            end
        end
        checkOutput("pronto_timeout", 32'(seen), 32'd1);
        checkOutput("latency", 32'(lat - 1), 32'(exp_lat));
        checkOutput("busy_cycles", 32'(busy_cycles), 32'(exp_lat));
        checkOutput("word", 32'(word), 32'(exp_word));
        checkOutput("sat", 32'(sat), 32'(exp_sat));
    endtask

    task automatic releaseStart(input logic [7:0] exp_word);
        start = 1'b0;
        @(negedge clk);
        checkOutput("release_pronto", 32'(pronto), 32'd0);
        checkOutput("release_busy", 32'(busy), 32'd0);
        checkOutput("release_word", 32'(word), 32'(exp_word));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        count = 4'd0;
        repeat (2) @(negedge clk);
        cmp_on = 1'b1;
        checkOutput("reset_word", 32'(word), 32'd0);
        checkOutput("reset_pronto", 32'(pronto), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_sat", 32'(sat), 32'd0);
        reset = 1'b0;

        applyStimulus(4'd3, 8'h07, 1'b0, 4, 1'b0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("basic_hold_word", 32'(word), 32'h07);
        end
        releaseStart(8'h07);

        applyStimulus(4'd0, 8'h00, 1'b0, 1, 1'b0);
        releaseStart(8'h00);

        applyStimulus(4'd8, 8'hFF, 1'b0, 9, 1'b0);
        releaseStart(8'hFF);

        applyStimulus(4'd12, 8'hFF, 1'b1, 9, 1'b0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("hs_pronto", 32'(pronto), 32'd1);
            checkOutput("hs_word", 32'(word), 32'hFF);
            checkOutput("hs_busy", 32'(busy), 32'd0);
        end
        releaseStart(8'hFF);

        applyStimulus(4'd1, 8'h01, 1'b0, 2, 1'b0);
        releaseStart(8'h01);

        count = 4'd6;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midrst_word_before", 32'(word), 32'h03);
        checkOutput("midrst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("midrst_word", 32'(word), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_pronto", 32'(pronto), 32'd0);
        checkOutput("midrst_sat", 32'(sat), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_idle_busy", 32'(busy), 32'd0);
        applyStimulus(4'd2, 8'h03, 1'b0, 3, 1'b0);
        releaseStart(8'h03);

        applyStimulus(4'd5, 8'h1F, 1'b0, 6, 1'b1);
        releaseStart(8'h1F);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
